// File: rtl/arb_pkg.sv
// +-------------------------------------------------------------------------+
// | arb_pkg: shared types and constants for the arbitro_rr arbiter           |
// | Revision: 1.0 - initial release                                          |
// +-------------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

    localparam int c_num_req = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Segment order is {a,b,c,d,e,f,g}, active high.
    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    // Searches ptr+1, ptr+2, ptr+3, ptr; walking backwards lets the
    // highest-priority hit overwrite the lower ones.
    function automatic rr_pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        rr_pick_t   r;
        logic [1:0] idx;
        r.found = 1'b0;
        r.idx   = ptr;
        for (int i = c_num_req; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dec_7seg.sv
// +-------------------------------------------------------------------------+
// | dec_7seg: 2-bit index to 7-segment pattern, dash when not valid          |
// | Revision: 1.0 - initial release                                          |
// +-------------------------------------------------------------------------+
`default_nettype none

module dec_7seg
    import arb_pkg::*;
(
    input  logic [1:0] i_idx,
    input  logic       i_valid,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_valid) begin
            case (i_idx)
                2'd0:    o_seg = SEG_0;
                2'd1:    o_seg = SEG_1;
                2'd2:    o_seg = SEG_2;
                default: o_seg = SEG_3;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/arbitro_rr.sv
// +-------------------------------------------------------------------------+
// | arbitro_rr: 4-way round-robin arbiter with hold-until-release grants,    |
// | one-cycle gap after each release and 7-segment index display.            |
// | Optional grant timeout enabled by defining ARB_TIMEOUT_EN.               |
// | Revision: 1.0 - initial release                                          |
// +-------------------------------------------------------------------------+
`default_nettype none

module arbitro_rr
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] y,
    output logic       valid,
    output logic [6:0] seg
);

    arb_state_e state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] y_q, y_d;
    logic [1:0] ptr_q, ptr_d;
    rr_pick_t   w_pick;
    logic       w_release;

`ifdef ARB_TIMEOUT_EN
    logic [3:0] hold_q, hold_d;
    logic       w_hold_expired;

    assign w_hold_expired = (hold_q == 4'(HOLD_MAX - 1));
    assign w_release      = !req[y_q] || w_hold_expired;
`else
    logic [3:0] unused_hold_max;

    assign unused_hold_max = 4'(HOLD_MAX);
    assign w_release       = !req[y_q];
`endif

    always_comb begin
        w_pick  = rr_pick(req, ptr_q);
        state_d = state_q;
        gnt_d   = gnt_q;
        y_d     = y_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_pick.found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << w_pick.idx;
                    y_d     = w_pick.idx;
                    ptr_d   = w_pick.idx;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 4'd0;
`endif
                end
            end
            GRANT: begin
                if (w_release) begin
                    state_d = GAP;
                    gnt_d   = 4'b0000;
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    hold_d = hold_q + 4'd1;
                end
`endif
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // ptr resets to 3 so requester 0 is first in the search order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            y_q     <= 2'd0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= 4'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign gnt   = gnt_q;
    assign y     = y_q;
    assign valid = |gnt_q;

    dec_7seg u_dec_7seg (
        .i_idx   (y_q),
        .i_valid (valid),
        .o_seg   (seg)
    );

endmodule

`default_nettype wire
